uart_loader: RTL and testbench

- Bus initiator that drives the memory-mapped UART register port (UDR/UCR) from the programmer side.
- After `start`, it pulls a length-prefixed binary image out of the UART RX FIFO byte by byte and assembles 32-bit little-endian words.
- Each word is written to instruction memory; a 1-byte checksum is then echoed back through the TX FIFO.
- Holds the CPU in reset for the whole load and releases it on success. Sits between the UART peripheral and the imem write port, beside the core.

---
 rtl/uart_loader_pkg.sv | 32 +++
 rtl/uart_loader_if.sv | 29 ++
 rtl/uart_word_asm.sv | 49 ++++
 rtl/uart_loader.sv | 177 +++++++++++++++++
 tb/tb_uart_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART image loader.
//   state_t  : loader FSM states
//   phase_t  : whether incoming bytes are the length prefix or payload
//   ERR_*    : errCode values reported on abort
//   byteAddr : byte address of a word index relative to a base
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    MEM_WR,
    TX_SUM,
    DONE,
    ERR
  } state_t;

  typedef enum logic {
    LEN,
    DATA
  } phase_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ZERO    = 2'd1;
  localparam logic [1:0] ERR_BIG     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic logic [31:0] byteAddr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Bus bundle between the loader and its two targets.
//   UART register port : uAddr, uWrData, uWrEn, uRdEn (loader drives),
//                        uDataOut, uOutEn, uRxFfEmpty (UART drives)
//   imem write port    : memAddr, memWrData, memWrEn (loader drives)
// master = loader side, slave = UART/imem side.
interface uart_loader_if;

  logic [10:0] uAddr;
  logic [31:0] uWrData;
  logic        uWrEn;
  logic        uRdEn;
  logic [31:0] uDataOut;
  logic        uOutEn;
  logic        uRxFfEmpty;
  logic [31:0] memAddr;
  logic [31:0] memWrData;
  logic        memWrEn;

  modport master (
    output uAddr, uWrData, uWrEn, uRdEn, memAddr, memWrData, memWrEn,
    input  uDataOut, uOutEn, uRxFfEmpty
  );

  modport slave (
    input  uAddr, uWrData, uWrEn, uRdEn, memAddr, memWrData, memWrEn,
    output uDataOut, uOutEn, uRxFfEmpty
  );

endinterface

// File: rtl/uart_word_asm.sv
// Assembles received bytes into a 32-bit little-endian word and keeps an
// 8-bit wrap-around sum of the bytes accepted while sumEn is high.
//   clk, rstB : clock, synchronous active-low reset
//   byteIn    : received byte, accepted when valid=1
//   valid     : byte strobe
//   clear     : restart slot counter, word and sum
//   sumEn     : include accepted bytes in the sum
//   word      : assembled word, already including the byte being accepted
//   wordValid : high together with the 4th byte of a word
//   sum       : running checksum
module uart_word_asm
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstB,
  input  logic [7:0]  byteIn,
  input  logic        valid,
  input  logic        clear,
  input  logic        sumEn,
  output logic [31:0] word,
  output logic        wordValid,
  output logic [7:0]  sum
);

  logic [3:0][7:0] slots;
  logic [1:0]      byteCnt;

  // The incoming byte is merged combinationally so the FSM can act on the
  // complete word in the same cycle the 4th byte arrives.
  always_comb begin
    word = slots;
    if (valid) word[{byteCnt, 3'b000} +: 8] = byteIn;
  end

  assign wordValid = valid && (byteCnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rstB || clear) begin
      slots   <= '0;
      byteCnt <= '0;
      sum     <= '0;
    end else if (valid) begin
      slots[byteCnt] <= byteIn;
      byteCnt        <= byteCnt + 2'd1;
      if (sumEn) sum <= sum + byteIn;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Programmer-side bus initiator: pulls a length-prefixed image from the UART
// RX FIFO, writes it word by word into instruction memory, echoes an 8-bit
// payload checksum through the TX FIFO and holds the CPU in reset until a
// load succeeds.
//   clk, rstB : clock, synchronous active-low reset
//   start     : level, begins a load from IDLE/DONE/ERR
//   bus       : UART register port + imem write port (master side)
//   busy      : load in progress
//   done/err  : last load succeeded / aborted
//   errCode   : abort reason (ERR_* in the package)
//   cpuRstB   : active-low CPU reset, released only in DONE
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [10:0] UDR_ADDR       = 11'h402,
  parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rstB,
  input  logic                 start,
  uart_loader_if.master        bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           errCode,
  output logic                 cpuRstB
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  state_t             state;
  phase_t             phase;
  logic [IDX_W-1:0]   nWords;
  logic [IDX_W-1:0]   wordIdx;
  logic [31:0]        toCnt;
  logic [31:0]        asmWord;
  logic               asmWordValid;
  logic [7:0]         asmSum;
  logic               capture;
  logic               clearAsm;
  logic               unusedDataHi;

  assign capture      = (state == RD_WAIT) && bus.uOutEn;
  assign clearAsm     = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign unusedDataHi = ^bus.uDataOut[31:8];

  // Read strobe is decoded from state so a byte costs only two cycles
  // (RD_REQ, then RD_WAIT with uOutEn); gated by rstB so no strobe leaves
  // during a reset cycle.
  assign bus.uRdEn = rstB && (state == RD_REQ) && !bus.uRxFfEmpty;

  uart_word_asm uAsm (
    .clk       (clk),
    .rstB      (rstB),
    .byteIn    (bus.uDataOut[7:0]),
    .valid     (capture),
    .clear     (clearAsm),
    .sumEn     (phase == DATA),
    .word      (asmWord),
    .wordValid (asmWordValid),
    .sum       (asmSum)
  );

  always_ff @(posedge clk) begin
    if (!rstB) begin
      state         <= IDLE;
      phase         <= LEN;
      nWords        <= '0;
      wordIdx       <= '0;
      toCnt         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      errCode       <= ERR_NONE;
      cpuRstB       <= 1'b0;
      bus.uAddr     <= '0;
      bus.uWrData   <= '0;
      bus.uWrEn     <= 1'b0;
      bus.memAddr   <= '0;
      bus.memWrData <= '0;
      bus.memWrEn   <= 1'b0;
    end else begin
      bus.memWrEn <= 1'b0;
      bus.uWrEn   <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= RD_REQ;
            phase     <= LEN;
            nWords    <= '0;
            wordIdx   <= '0;
            toCnt     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            errCode   <= ERR_NONE;
            cpuRstB   <= 1'b0;
            bus.uAddr <= UDR_ADDR;
          end
        end

        RD_REQ: begin
          if (!bus.uRxFfEmpty) begin
            toCnt <= '0;
            state <= RD_WAIT;
          end else begin
            toCnt <= toCnt + 32'd1;
            if ((TIMEOUT_CYCLES != 0) && (toCnt + 32'd1 == TIMEOUT_CYCLES)) begin
              state     <= ERR;
              err       <= 1'b1;
              errCode   <= ERR_TIMEOUT;
              busy      <= 1'b0;
              bus.uAddr <= '0;
            end
          end
        end

        RD_WAIT: begin
          if (bus.uOutEn) begin
            if (!asmWordValid) begin
              state <= RD_REQ;
            end else if (phase == LEN) begin
              if (asmWord == '0) begin
                state     <= ERR;
                err       <= 1'b1;
                errCode   <= ERR_ZERO;
                busy      <= 1'b0;
                bus.uAddr <= '0;
              end else if (asmWord > 32'(MAX_WORDS)) begin
                state     <= ERR;
                err       <= 1'b1;
                errCode   <= ERR_BIG;
                busy      <= 1'b0;
                bus.uAddr <= '0;
              end else begin
                nWords <= asmWord[IDX_W-1:0];
                phase  <= DATA;
                state  <= RD_REQ;
              end
            end else begin
              // Strobe is registered here so it is high in the cycle right
              // after the 4th byte is captured; MEM_WR only bookkeeps.
              bus.memWrEn   <= 1'b1;
              bus.memAddr   <= byteAddr(IMEM_BASE, 32'(wordIdx));
              bus.memWrData <= asmWord;
              state         <= MEM_WR;
            end
          end
        end

        MEM_WR: begin
          wordIdx <= wordIdx + IDX_W'(1);
          if (wordIdx + IDX_W'(1) == nWords) begin
            bus.uWrEn   <= 1'b1;
            bus.uWrData <= {24'h0, asmSum};
            state       <= TX_SUM;
          end else begin
            state <= RD_REQ;
          end
        end

        TX_SUM: begin
          state     <= DONE;
          done      <= 1'b1;
          busy      <= 1'b0;
          cpuRstB   <= 1'b1;
          bus.uAddr <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader. Instance 0 has the timeout disabled,
// instance 1 uses a 100-cycle timeout. Each instance has a simple UART RX
// model (byte array + read pointer) and a monitor that logs strobes.
module tb_uart_loader;

  logic       clk = 1'b0;
  logic       rstB;
  logic       start [2];
  logic [7:0] rxMem [2][256];
  int         wrPtr [2] = '{0, 0};
  int         cyc = 0;
  int         vecs = 0;
  int         errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : u
    uart_loader_if bus();
    logic        busy, done, err, cpuRstB;
    logic [1:0]  errCode;
    int          rdPtr = 0;
    int          nMemWr = 0, nUWr = 0, nRd = 0;
    int          emptyRdViol = 0, bothViol = 0, latViol = 0, dblRd = 0;
    logic [31:0] wrAddr [16];
    logic [31:0] wrData [16];
    logic [31:0] txData = '0;
    logic        prevOutEn = 1'b0, prevRdEn = 1'b0, errQ = 1'b0;
    int          lastOutCyc = 0, errCyc = 0;

    assign bus.uRxFfEmpty = (rdPtr == wrPtr[g]);

    uart_loader #(.TIMEOUT_CYCLES((g == 0) ? 0 : 100)) dut (
      .clk     (clk),
      .rstB    (rstB),
      .start   (start[g]),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .errCode (errCode),
      .cpuRstB (cpuRstB)
    );

    always @(posedge clk) begin
      bus.uOutEn <= 1'b0;
      if (bus.uRdEn === 1'b1) begin
        bus.uDataOut <= {24'h0, rxMem[g][rdPtr % 256]};
        bus.uOutEn   <= 1'b1;
        rdPtr        <= rdPtr + 1;
        nRd          <= nRd + 1;
        if (bus.uRxFfEmpty) emptyRdViol <= emptyRdViol + 1;
        if (bus.uWrEn === 1'b1) bothViol <= bothViol + 1;
        if (prevRdEn) dblRd <= dblRd + 1;
      end
      if (bus.uOutEn === 1'b1) lastOutCyc <= cyc;
      if (bus.memWrEn === 1'b1) begin
        wrAddr[nMemWr % 16] <= bus.memAddr;
        wrData[nMemWr % 16] <= bus.memWrData;
        nMemWr              <= nMemWr + 1;
        if (!prevOutEn) latViol <= latViol + 1;
      end
      if (bus.uWrEn === 1'b1) begin
        txData <= bus.uWrData;
        nUWr   <= nUWr + 1;
      end
      prevOutEn <= (bus.uOutEn === 1'b1);
      prevRdEn  <= (bus.uRdEn === 1'b1);
      errQ      <= (err === 1'b1);
      if ((err === 1'b1) && !errQ) errCyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    rxMem[g][wrPtr[g] % 256] = b;
    wrPtr[g]++;
  endtask

  task automatic pulseStart(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic waitEnd0(input int maxc);
    int n = 0;
    while (!(u[0].done === 1'b1 || u[0].err === 1'b1) && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int mw, uw, rd;
    logic [7:0] nomImg [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] bpImg [8]   = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] partImg [10] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                                 8'h55, 8'h66};
    logic [7:0] freshImg [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    rstB = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state
    chk("rst_busy",    u[0].busy, 0);
    chk("rst_done",    u[0].done, 0);
    chk("rst_err",     u[0].err, 0);
    chk("rst_errCode", u[0].errCode, 0);
    chk("rst_cpuRstB", u[0].cpuRstB, 0);
    chk("rst_uAddr",   u[0].bus.uAddr, 0);
    chk("rst_memWrEn", u[0].bus.memWrEn, 0);
    chk("rst_uWrEn",   u[0].bus.uWrEn, 0);
    chk("rst_uRdEn",   u[0].bus.uRdEn, 0);
    chk("rst_memAddr", u[0].bus.memAddr, 0);
    rstB = 1'b1;
    repeat (2) @(negedge clk);

    // nominal two-word load
    foreach (nomImg[i]) push(0, nomImg[i]);
    mw = u[0].nMemWr; uw = u[0].nUWr; rd = u[0].nRd;
    pulseStart(0);
    chk("nom_busy",    u[0].busy, 1);
    chk("nom_uAddr",   u[0].bus.uAddr, 32'h402);
    chk("nom_cpuHeld", u[0].cpuRstB, 0);
    waitEnd0(500);
    chk("nom_done",    u[0].done, 1);
    chk("nom_err",     u[0].err, 0);
    chk("nom_cpuRstB", u[0].cpuRstB, 1);
    chk("nom_idle",    u[0].busy, 0);
    chk("nom_uAddr0",  u[0].bus.uAddr, 0);
    chk("nom_nWr",     u[0].nMemWr - mw, 2);
    chk("nom_addr0",   u[0].wrAddr[mw % 16], 32'h0);
    chk("nom_data0",   u[0].wrData[mw % 16], 32'h12345678);
    chk("nom_addr1",   u[0].wrAddr[(mw + 1) % 16], 32'h4);
    chk("nom_data1",   u[0].wrData[(mw + 1) % 16], 32'hDEADBEEF);
    chk("nom_nTx",     u[0].nUWr - uw, 1);
    chk("nom_sum",     u[0].txData, 32'h4C);
    chk("nom_nRd",     u[0].nRd - rd, 12);
    chk("nom_memLat",  u[0].latViol, 0);
    chk("nom_holdA",   u[0].bus.memAddr, 32'h4);
    chk("nom_holdD",   u[0].bus.memWrData, 32'hDEADBEEF);

    // zero length, restarted from DONE
    repeat (4) push(0, 8'h00);
    mw = u[0].nMemWr; uw = u[0].nUWr;
    pulseStart(0);
    chk("zero_cpuRe",  u[0].cpuRstB, 0);
    chk("zero_busy",   u[0].busy, 1);
    waitEnd0(200);
    chk("zero_err",    u[0].err, 1);
    chk("zero_code",   u[0].errCode, 1);
    chk("zero_done",   u[0].done, 0);
    chk("zero_nWr",    u[0].nMemWr - mw, 0);
    chk("zero_nTx",    u[0].nUWr - uw, 0);
    chk("zero_cpu",    u[0].cpuRstB, 0);
    chk("zero_busy0",  u[0].busy, 0);

    // oversize length 1025, restarted from ERR
    push(0, 8'h01); push(0, 8'h04); push(0, 8'h00); push(0, 8'h00);
    mw = u[0].nMemWr;
    pulseStart(0);
    waitEnd0(200);
    chk("big_err",     u[0].err, 1);
    chk("big_code",    u[0].errCode, 2);
    chk("big_nWr",     u[0].nMemWr - mw, 0);
    chk("big_cpu",     u[0].cpuRstB, 0);

    // backpressure: 500-cycle gaps, no timeout
    mw = u[0].nMemWr; uw = u[0].nUWr; rd = u[0].nRd;
    pulseStart(0);
    foreach (bpImg[i]) begin
      repeat (500) @(negedge clk);
      if (i == 2) begin
        chk("bp_busyGap", u[0].busy, 1);
        chk("bp_noTo",    u[0].err, 0);
      end
      push(0, bpImg[i]);
    end
    waitEnd0(200);
    chk("bp_done",     u[0].done, 1);
    chk("bp_nWr",      u[0].nMemWr - mw, 1);
    chk("bp_addr",     u[0].wrAddr[mw % 16], 32'h0);
    chk("bp_data",     u[0].wrData[mw % 16], 32'h04030201);
    chk("bp_sum",      u[0].txData, 32'h0A);
    chk("bp_nTx",      u[0].nUWr - uw, 1);
    chk("bp_nRd",      u[0].nRd - rd, 8);
    chk("bp_rdEmpty",  u[0].emptyRdViol, 0);
    chk("bp_dblRd",    u[0].dblRd, 0);
    chk("bp_rdWr",     u[0].bothViol, 0);

    // reset in the middle of a two-word load, then a fresh image
    mw = u[0].nMemWr;
    foreach (partImg[i]) push(0, partImg[i]);
    pulseStart(0);
    for (int n = 0; n < 200 && u[0].rdPtr != wrPtr[0]; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid_busy",    u[0].busy, 1);
    chk("mid_nWr",     u[0].nMemWr - mw, 1);
    chk("mid_data",    u[0].wrData[mw % 16], 32'h44332211);
    rstB = 1'b0;
    @(negedge clk);
    chk("mid_rstBusy", u[0].busy, 0);
    chk("mid_rstMem",  u[0].bus.memWrEn, 0);
    chk("mid_rstRd",   u[0].bus.uRdEn, 0);
    chk("mid_rstDone", u[0].done, 0);
    rstB = 1'b1;
    @(negedge clk);
    mw = u[0].nMemWr; uw = u[0].nUWr;
    foreach (freshImg[i]) push(0, freshImg[i]);
    pulseStart(0);
    waitEnd0(300);
    chk("rst2_done",   u[0].done, 1);
    chk("rst2_nWr",    u[0].nMemWr - mw, 1);
    chk("rst2_addr",   u[0].wrAddr[mw % 16], 32'h0);
    chk("rst2_data",   u[0].wrData[mw % 16], 32'hDDCCBBAA);
    chk("rst2_sum",    u[0].txData, 32'h0E);
    chk("rst2_nTx",    u[0].nUWr - uw, 1);
    chk("rst2_memLat", u[0].latViol, 0);

    // timeout on instance 1: length 1, then only 2 payload bytes
    push(1, 8'h01); push(1, 8'h00); push(1, 8'h00); push(1, 8'h00);
    push(1, 8'h11); push(1, 8'h22);
    pulseStart(1);
    for (int n = 0; n < 60; n++) begin
      if (u[1].err === 1'b1) break;
      @(negedge clk);
    end
    chk("to_early",    u[1].err, 0);
    for (int n = 0; n < 400; n++) begin
      if (u[1].err === 1'b1) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("to_err",      u[1].err, 1);
    chk("to_code",     u[1].errCode, 3);
    chk("to_nWr",      u[1].nMemWr, 0);
    chk("to_done",     u[1].done, 0);
    chk("to_cpu",      u[1].cpuRstB, 0);
    chk("to_cycles",   u[1].errCyc - u[1].lastOutCyc, 101);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
